// File: rtl/rc5_pkg.sv
// Shared RC5-32 constants, state encoding and sizing helpers.
// Latency: n/a (package only).
// Backpressure: n/a. Imported by key expansion and the encrypt/decrypt rounds.
package rc5_pkg;

  // Magic constants of RC5-32 (derived from e and the golden ratio).
  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;

  localparam int RC5_ROUNDS    = 12;
  localparam int RC5_KEY_WORDS = 4;

  // Number of expanded round-key words.
  function automatic int rc5_t(input int rounds);
    return 2 * rounds + 2;
  endfunction

  // Default schedule length shared with the round pipelines.
  localparam int T = 2 * RC5_ROUNDS + 2;

  // Mixing iterations: three passes over the longer of the S and L arrays.
  function automatic int rc5_n_iter(input int t, input int c);
    return 3 * ((t > c) ? t : c);
  endfunction

  // Initial S table entry: P32 + k*Q32 mod 2^32.
  function automatic logic [31:0] rc5_s_init(input int k);
    return P32 + (32'(k) * Q32);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_DONE = 2'd2
  } rc5_state_e;

endpackage

// File: rtl/rc5_rotl32.sv
// Combinational 32-bit rotate-left by a 5-bit amount.
// Latency: 0 cycles (pure combinational).
// Backpressure: none. Ports: din (operand), amt (rotate amount), dout (result).
module rc5_rotl32 (
  input  logic [31:0] din,
  input  logic [4:0]  amt,
  output logic [31:0] dout
);

  // Right part is shifted by 1 + (31 - amt) so no shift ever reaches 32;
  // amt == 0 leaves only the left term, i.e. din unchanged.
  always_comb begin
    dout = (din << amt) | ((din >> 1) >> (~amt));
  end

endmodule

// File: rtl/rc5_key_expand.sv
// RC5-32 key schedule engine: one S/L mixing iteration per clock.
// Latency: 3*max(T,KEY_WORDS) cycles from key accept to skey_vld (78 at defaults).
// Backpressure: key_rdy low while mixing; key_vld then is ignored, not queued.
// Ports: clk, clr (sync active-high reset), key_in/key_vld/key_rdy (user key
// handshake), busy (mixing), skey_out/skey_vld (flat round-key bus, S[k] at
// bits 32k+31:32k). Optional macro RC5_KEYGEN_ZEROIZE_EN adds input zeroize,
// which wipes all key material exactly like clr.
module rc5_key_expand
  import rc5_pkg::*;
#(
  parameter int ROUNDS    = RC5_ROUNDS,
  parameter int KEY_WORDS = RC5_KEY_WORDS
) (
  input  logic                        clk,
  input  logic                        clr,
`ifdef RC5_KEYGEN_ZEROIZE_EN
  input  logic                        zeroize,
`endif
  input  logic [32*KEY_WORDS-1:0]     key_in,
  input  logic                        key_vld,
  output logic                        key_rdy,
  output logic                        busy,
  output logic [32*(2*ROUNDS+2)-1:0]  skey_out,
  output logic                        skey_vld
);

  localparam int NT    = rc5_t(ROUNDS);
  localparam int NITER = rc5_n_iter(NT, KEY_WORDS);
  localparam int IW    = (NT > 1) ? $clog2(NT) : 1;
  localparam int JW    = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int CW    = $clog2(NITER + 1);

  localparam logic [IW-1:0] I_LAST    = IW'(NT - 1);
  localparam logic [JW-1:0] J_LAST    = JW'(KEY_WORDS - 1);
  localparam logic [CW-1:0] ITER_LAST = CW'(NITER - 1);

  rc5_state_e     state_q, state_d;
  logic [31:0]    s_q [NT];
  logic [31:0]    s_d [NT];
  logic [31:0]    l_q [KEY_WORDS];
  logic [31:0]    l_d [KEY_WORDS];
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  logic [IW-1:0]  i_q, i_d;
  logic [JW-1:0]  j_q, j_d;
  logic [CW-1:0]  iter_q, iter_d;

  logic           wipe;
  logic           accept;
  logic [31:0]    sum_a, a_new;
  logic [31:0]    sum_ab, sum_b, b_new;

`ifdef RC5_KEYGEN_ZEROIZE_EN
  assign wipe = clr | zeroize;
`else
  assign wipe = clr;
`endif

  assign key_rdy  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy     = (state_q == ST_MIX);
  assign skey_vld = (state_q == ST_DONE);
  assign accept   = key_vld & key_rdy;

  // A' = rotl(S[i] + A + B, 3)
  assign sum_a = s_q[i_q] + a_q + b_q;
  rc5_rotl32 u_rotl_a (
    .din  (sum_a),
    .amt  (5'd3),
    .dout (a_new)
  );

  // B' = rotl(L[j] + A' + B, (A' + B) mod 32)
  assign sum_ab = a_new + b_q;
  assign sum_b  = l_q[j_q] + sum_ab;
  rc5_rotl32 u_rotl_b (
    .din  (sum_b),
    .amt  (sum_ab[4:0]),
    .dout (b_new)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    l_d     = l_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    iter_d  = iter_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          for (int k = 0; k < NT; k++) begin
            s_d[k] = rc5_s_init(k);
          end
          for (int k = 0; k < KEY_WORDS; k++) begin
            l_d[k] = key_in[32*k +: 32];
          end
          a_d     = '0;
          b_d     = '0;
          i_d     = '0;
          j_d     = '0;
          iter_d  = '0;
          state_d = ST_MIX;
        end
      end
      ST_MIX: begin
        s_d[i_q] = a_new;
        l_d[j_q] = b_new;
        a_d      = a_new;
        b_d      = b_new;
        i_d      = (i_q == I_LAST) ? '0 : i_q + 1'b1;
        j_d      = (j_q == J_LAST) ? '0 : j_q + 1'b1;
        iter_d   = iter_q + 1'b1;
        // The edge that performs the last iteration also enters DONE.
        if (iter_q == ITER_LAST) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < NT; k++) begin
        s_q[k] <= '0;
      end
      for (int k = 0; k < KEY_WORDS; k++) begin
        l_q[k] <= '0;
      end
      a_q    <= '0;
      b_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      iter_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      l_q     <= l_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      iter_q  <= iter_d;
    end
  end

  // S is presented directly; consumers only sample it while skey_vld is high.
  for (genvar g = 0; g < NT; g++) begin : g_skey
    assign skey_out[32*g +: 32] = s_q[g];
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed self-checking bench for rc5_key_expand at default parameters.
// Latency: checks the 78-cycle schedule and 79-cycle back-to-back period.
// Backpressure: checks key_rdy/busy and that key_vld during mixing is ignored.
module tb_rc5_key_expand;

  localparam int NT = 26;
  localparam int NI = 78;

  localparam logic [127:0] K_STD = 128'h91CEA910_01A55563_51B241BE_19465F91;
  localparam logic [127:0] K_ALT = 128'h915F4619BE41B2516355A50110A9CE91;

  logic              clk;
  logic              clr;
  logic [127:0]      key_in;
  logic              key_vld;
  logic              key_rdy;
  logic              busy;
  logic [32*NT-1:0]  skey_out;
  logic              skey_vld;
`ifdef RC5_KEYGEN_ZEROIZE_EN
  logic              zeroize;
`endif

  int checks;
  int failures;
  int cyc;

  rc5_key_expand dut (
    .clk      (clk),
    .clr      (clr),
`ifdef RC5_KEYGEN_ZEROIZE_EN
    .zeroize  (zeroize),
`endif
    .key_in   (key_in),
    .key_vld  (key_vld),
    .key_rdy  (key_rdy),
    .busy     (busy),
    .skey_out (skey_out),
    .skey_vld (skey_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  // Reference RC5-32/12/16 key schedule.
  function automatic logic [32*NT-1:0] ref_sched(input logic [127:0] key);
    logic [31:0]      s [NT];
    logic [31:0]      l [4];
    logic [31:0]      a, b;
    int               i, j;
    logic [32*NT-1:0] r;
    for (int k = 0; k < NT; k++) s[k] = 32'hB7E15163 + 32'(k) * 32'h9E3779B9;
    for (int k = 0; k < 4; k++) l[k] = key[32*k +: 32];
    a = 0; b = 0; i = 0; j = 0;
    for (int n = 0; n < NI; n++) begin
      a = rotl(s[i] + a + b, 3);
      s[i] = a;
      b = rotl(l[j] + a + b, int'((a + b) & 32'd31));
      l[j] = b;
      i = (i + 1) % NT;
      j = (j + 1) % 4;
    end
    for (int k = 0; k < NT; k++) r[32*k +: 32] = s[k];
    return r;
  endfunction

  // RC5 encryption of one block using a 26-word schedule; returns {A,B}.
  function automatic logic [63:0] encrypt(input logic [32*NT-1:0] sk,
                                          input logic [31:0] pa, input logic [31:0] pb);
    logic [31:0] a, b;
    a = pa + sk[31:0];
    b = pb + sk[63:32];
    for (int r = 1; r <= 12; r++) begin
      a = rotl(a ^ b, int'(b & 32'd31)) + sk[32*(2*r) +: 32];
      b = rotl(b ^ a, int'(a & 32'd31)) + sk[32*(2*r+1) +: 32];
    end
    return {a, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_sched(input string tag, input logic [127:0] key);
    logic [32*NT-1:0] e;
    e = ref_sched(key);
    for (int k = 0; k < NT; k++)
      chk($sformatf("%s_s%0d", tag, k), skey_out[32*k +: 32], e[32*k +: 32]);
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (!skey_vld && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, {31'b0, skey_vld}, 32'd1);
  endtask

  initial begin : main
    int          n;
    int          rdy_bad;
    int          last_rise;
    logic [63:0] ct;

    checks = 0; failures = 0; cyc = 0;
    clr = 1'b1; key_vld = 1'b0; key_in = '0;
`ifdef RC5_KEYGEN_ZEROIZE_EN
    zeroize = 1'b0;
`endif

    // Reset held three cycles, then released.
    tick(); tick(); tick();
    clr = 1'b0;
    tick();
    chk("rst_skey_vld", {31'b0, skey_vld}, 32'd0);
    chk("rst_busy",     {31'b0, busy},     32'd0);
    chk("rst_key_rdy",  {31'b0, key_rdy},  32'd1);
    chk("rst_skey_zero", {31'b0, |skey_out}, 32'd0);

    // Zero key, single-cycle pulse: latency and handshake.
    key_in = '0; key_vld = 1'b1;
    tick();
    key_vld = 1'b0;
    n = 0; rdy_bad = 0;
    while (busy && n < 200) begin
      if (key_rdy) rdy_bad++;
      if (skey_vld) rdy_bad++;
      n++;
      tick();
    end
    chk("busy_cycles",   n,                    NI);
    chk("rdy_low_mix",   rdy_bad,              0);
    chk("lat_skey_vld",  {31'b0, skey_vld},    32'd1);
    chk("done_key_rdy",  {31'b0, key_rdy},     32'd1);
    chk_sched("zero", '0);
    ct = encrypt(skey_out, 32'h0, 32'h0);
    chk("ct0_a", ct[63:32], 32'hEEDBA521);
    chk("ct0_b", ct[31:0],  32'h6D8F4B15);

    // DONE holds its schedule while idle.
    tick(); tick();
    chk("done_hold_vld", {31'b0, skey_vld}, 32'd1);
    chk_sched("zero_hold", '0);

    // Standard key; a different key offered mid-mix must be ignored.
    key_in = K_STD; key_vld = 1'b1;
    tick();
    key_vld = 1'b0;
    chk("accept_drop_vld", {31'b0, skey_vld}, 32'd0);
    for (int k = 0; k < 10; k++) tick();
    key_in = K_ALT; key_vld = 1'b1;
    chk("mix_key_rdy", {31'b0, key_rdy}, 32'd0);
    tick();
    key_vld = 1'b0;
    wait_vld("ign");
    chk_sched("ign", K_STD);
    ct = encrypt(skey_out, 32'hEEDBA521, 32'h6D8F4B15);
    chk("ct1_a", ct[63:32], 32'hAC13C0F7);
    chk("ct1_b", ct[31:0],  32'h52892B5B);

    // Back-to-back with key_vld held high, keys alternating.
    key_in = '0; key_vld = 1'b1;
    tick();
    last_rise = -1;
    for (int s = 0; s < 4; s++) begin
      wait_vld($sformatf("b2b%0d", s));
      if (last_rise >= 0) chk($sformatf("b2b_period%0d", s), cyc - last_rise, 79);
      last_rise = cyc;
      chk_sched($sformatf("b2b%0d", s), (s % 2 == 1) ? K_ALT : 128'h0);
      key_in = (s % 2 == 0) ? K_ALT : 128'h0;
      if (s == 3) key_vld = 1'b0;
      tick();
      if (s < 3) chk($sformatf("b2b_drop%0d", s), {31'b0, skey_vld}, 32'd0);
    end

    // clr in the middle of mixing.
    key_in = K_ALT; key_vld = 1'b1;
    tick();
    key_vld = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_mix_busy",    {31'b0, busy},      32'd0);
    chk("clr_mix_key_rdy", {31'b0, key_rdy},   32'd1);
    chk("clr_mix_vld",     {31'b0, skey_vld},  32'd0);
    chk("clr_mix_zero",    {31'b0, |skey_out}, 32'd0);
    for (int k = 0; k < 80; k++) tick();
    chk("clr_mix_vld_late", {31'b0, skey_vld}, 32'd0);

`ifdef RC5_KEYGEN_ZEROIZE_EN
    // zeroize in DONE wipes the schedule.
    key_in = K_ALT; key_vld = 1'b1;
    tick();
    key_vld = 1'b0;
    wait_vld("zz");
    chk_sched("zz", K_ALT);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("zz_done_vld",  {31'b0, skey_vld},  32'd0);
    chk("zz_done_zero", {31'b0, |skey_out}, 32'd0);
    chk("zz_done_rdy",  {31'b0, key_rdy},   32'd1);
    // zeroize during mixing returns to IDLE.
    key_vld = 1'b1;
    tick();
    key_vld = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("zz_mix_busy", {31'b0, busy},    32'd0);
    chk("zz_mix_rdy",  {31'b0, key_rdy}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
